// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD <-> binary converters.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } bcd_state_t;

   // Bits needed to hold 10**ndigits - 1.
   function automatic int bcd_bin_width(input int ndigits);
      longint p;
      int     w;
      p = 1;
      for (int i = 0; i < ndigits; i++) p = p * 10;
      w = 0;
      while ((longint'(1) << w) < p) w++;
      return w;
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit, truncated to BIN_W, with an optional invalid-digit flag.
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int BIN_W    = 14,
   parameter bit CHECK_EN = 1'b1
) (
   input  logic [BIN_W-1:0] acc,
   input  bcd_digit_t       digit,
   output logic [BIN_W-1:0] result,
   output logic             digit_err
);

   // x*10 as x*8 + x*2 keeps the multiply out of a DSP and in plain adders.
   assign result = (acc << 3) + (acc << 1) + BIN_W'(digit);

   generate
      if (CHECK_EN) begin : gen_chk
         assign digit_err = (digit > BCD_MAX_DIGIT);
      end else begin : gen_nochk
         assign digit_err = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock MSD first.
// Optional build macro BCD2BIN_ERR_EN adds sticky invalid-digit detection.
module bcd2bin_seq
   import bcd_pkg::*;
#(
   parameter  int NDIGITS = 4,
   localparam int BIN_W   = bcd_bin_width(NDIGITS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4*NDIGITS-1:0]   in_bcd,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [BIN_W-1:0]       out_bin,
   output logic                   out_err,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int CNT_W = 4;

   bcd_state_t           state_reg, state_next;
   logic [BIN_W-1:0]     acc_reg, acc_next;
   logic [4*NDIGITS-1:0] shift_reg, shift_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [BIN_W-1:0]     mac_result;
   logic                 mac_err;

`ifdef BCD2BIN_ERR_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   bcd_mac10 #(
      .BIN_W    (BIN_W),
      .CHECK_EN (CHECK_EN)
   ) u_mac (
      .acc       (acc_reg),
      .digit     (shift_reg[4*NDIGITS-1 -: 4]),
      .result    (mac_result),
      .digit_err (mac_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         shift_reg <= shift_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      shift_next = shift_reg;
      cnt_next   = cnt_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shift_next = in_bcd;
               acc_next   = '0;
               cnt_next   = '0;
               state_next = CONV;
            end
         end
         CONV: begin
            acc_next   = mac_result;
            shift_next = shift_reg << 4;
            cnt_next   = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(NDIGITS - 1)) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef BCD2BIN_ERR_EN
   logic err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_reg <= 1'b0;
      end else if (state_reg == IDLE && in_valid) begin
         err_reg <= 1'b0;
      end else if (state_reg == CONV && mac_err) begin
         err_reg <= 1'b1;
      end
   end

   assign out_err = err_reg;
   assign out_bin = err_reg ? '0 : acc_reg;
`else
   // The multiplier is built without checking, so its flag is a constant 0.
   assign out_err = mac_err;
   assign out_bin = acc_reg;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Randomized self-checking bench for bcd2bin_seq against a positional-sum reference model.
module tb_bcd2bin_seq;

   localparam int NDIGITS = 4;
   localparam int BIN_W   = $clog2(10 ** NDIGITS);
   localparam int W       = 4 * NDIGITS;

   logic             clk;
   logic             rst_n;
   logic [W-1:0]     in_bcd;
   logic             in_valid;
   logic             in_ready;
   logic [BIN_W-1:0] out_bin;
   logic             out_err;
   logic             out_valid;
   logic             out_ready;

   bcd2bin_seq #(.NDIGITS(NDIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_bcd    (in_bcd),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_bin   (out_bin),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: value = sum(d_i * 10**i) mod 2**BIN_W; any digit >9 flags an error.
   function automatic logic [BIN_W:0] model(input logic [W-1:0] word);
      longint v, p;
      logic   bad;
      logic [3:0] d;
      v = 0; p = 1; bad = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         d = word[4*i +: 4];
         v = v + longint'(d) * p;
         p = p * 10;
         if (d > 4'd9) bad = 1'b1;
      end
`ifdef BCD2BIN_ERR_EN
      if (bad) return {1'b1, {BIN_W{1'b0}}};
      return {1'b0, BIN_W'(v % (longint'(1) << BIN_W))};
`else
      return {1'b0, BIN_W'(v % (longint'(1) << BIN_W))};
`endif
   endfunction

   // Scoreboard/monitor
   logic [BIN_W:0]   exp_q[$];
   int               acc_q[$];
   int               cyc = 0;
   int               n_accept = 0;
   int               last_acc = 0;
   bit               spacing_chk = 1'b0;
   bit               rand_ready = 1'b0;
   logic             prev_ov = 1'b0;
   logic             prev_or = 1'b0;
   logic [BIN_W-1:0] prev_bin = '0;
   logic             prev_oerr = 1'b0;
   logic [BIN_W:0]   e;

   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         acc_q.delete();
         prev_ov = 1'b0;
      end else begin
         if (acc_q.size() > 0) check("ready_busy", in_ready, 0);
         if (out_valid && !prev_ov && acc_q.size() > 0)
            check("latency", (cyc - 1) - acc_q[0], NDIGITS);
         if (out_valid && prev_ov && !prev_or) begin
            check("hold_bin", out_bin, prev_bin);
            check("hold_err", out_err, prev_oerr);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("orphan", 1, 0);
            end else begin
               e = exp_q.pop_front();
               void'(acc_q.pop_front());
               check("out_bin", out_bin, e[BIN_W-1:0]);
               check("out_err", out_err, e[BIN_W]);
               $display("word done: bin=%0d err=%0b", out_bin, out_err);
            end
         end
         if (in_valid && in_ready) begin
            if (spacing_chk) check("spacing", cyc - last_acc, NDIGITS + 2);
            last_acc = cyc;
            exp_q.push_back(model(in_bcd));
            acc_q.push_back(cyc);
            n_accept++;
            $display("word in: bcd=%h", in_bcd);
         end
         prev_ov = out_valid;
      end
      prev_or   = out_ready;
      prev_bin  = out_bin;
      prev_oerr = out_err;
      cyc++;
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send(input logic [W-1:0] w, input bit hold);
      int n0;
      bit ok;
      n0 = n_accept;
      ok = 1'b0;
      in_bcd   = w;
      in_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (n_accept != n0) begin ok = 1'b1; break; end
      end
      check("accept_timeout", ok, 1);
      if (!hold) in_valid = 1'b0;
      in_bcd = W'($urandom);
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("done_timeout", ok, 1);
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      for (int i = 0; i < NDIGITS; i++)
         w[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      return w;
   endfunction

   initial begin
      bit seen;
      rst_n     = 1'b0;
      in_bcd    = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_bin", out_bin, 0);
      check("rst_out_err", out_err, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      send(W'(16'h0137), 1'b0);
      wait_done();

      send(W'(16'h9999), 1'b1);
      in_bcd = W'(16'h0000);
      spacing_chk = 1'b1;
      send(W'(16'h0000), 1'b0);
      spacing_chk = 1'b0;
      wait_done();

      out_ready = 1'b0;
      send(W'(16'h4025), 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid) begin seen = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("stall_valid_timeout", seen, 1);
      repeat (5) @(posedge clk);
      #1;
      check("stall_still_valid", out_valid, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_release", out_valid, 0);
      wait_done();

      send(W'(16'h12A4), 1'b0);
      wait_done();

      send(W'(16'h5678), 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_bin", out_bin, 0);
      check("mid_rst_out_err", out_err, 0);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("no_partial", seen, 0);
      send(W'(16'h0042), 1'b0);
      wait_done();

      rand_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         send(rand_word(), 1'b0);
         if ($urandom_range(0, 3) == 0) wait_done();
      end
      wait_done();
      rand_ready = 1'b0;
      out_ready = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
